// File: rtl/risk_gate_pipe.sv
// risk_gate_pipe: pipelined pre-trade risk gate.
//
// Keeps a per-client table of {max, acc, cxl} for 2**ID_W clients. Each request
// (ORDER, CANCEL, SETMAX, CLEAR) is evaluated in order and produces one response.
//
// Pipeline:
//   S1 - captures the request and a snapshot of its table entry.
//   S2 - holds the request and snapshot. At the next advancing edge it computes the
//        new entry, writes the table and loads the response register.
// Every stage moves only when adv = !rsp_valid || rsp_ready. A response stall
// therefore freezes the table and both stages.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake; req_ready == adv
//   req_op/id/amt     request type, client index, amount
//   rsp_valid/ready   response handshake
//   rsp_op/id         echo of the request
//   rsp_accept        order passed (always 1 for non-ORDER ops)
//   rsp_headroom      max - net after the op, clamped at 0
//   rej_count         saturating count of rejected orders (only with RISK_REJCNT_EN)
//
// Optional feature macro: RISK_REJCNT_EN adds rej_count and its counter.

module risk_gate_pipe #(
  parameter int unsigned ID_W  = 5,
  parameter int unsigned AMT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [ID_W-1:0]  req_id,
  input  logic [AMT_W-1:0] req_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_op,
  output logic [ID_W-1:0]  rsp_id,
  output logic             rsp_accept,
  output logic [AMT_W-1:0] rsp_headroom
`ifdef RISK_REJCNT_EN
  ,
  output logic [15:0]      rej_count
`endif
);

  localparam int unsigned Depth = 2 ** ID_W;

  typedef enum logic [1:0] {
    OpOrder  = 2'b00,
    OpCancel = 2'b01,
    OpSetMax = 2'b10,
    OpClear  = 2'b11
  } op_e;

  // Add two amounts, sticking at all-ones instead of wrapping.
  function automatic logic [AMT_W-1:0] sat_add(input logic [AMT_W-1:0] a,
                                               input logic [AMT_W-1:0] b);
    logic [AMT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[AMT_W] ? '1 : sum[AMT_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Client table
  // ---------------------------------------------------------------------------
  logic [AMT_W-1:0] max_q [Depth];
  logic [AMT_W-1:0] acc_q [Depth];
  logic [AMT_W-1:0] cxl_q [Depth];

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic             adv;

  logic             s1_valid_q;
  op_e              s1_op_q;
  logic [ID_W-1:0]  s1_id_q;
  logic [AMT_W-1:0] s1_amt_q;
  logic [AMT_W-1:0] s1_max_q, s1_acc_q, s1_cxl_q;

  logic             s2_valid_q;
  op_e              s2_op_q;
  logic [ID_W-1:0]  s2_id_q;
  logic [AMT_W-1:0] s2_amt_q;
  logic [AMT_W-1:0] s2_max_q, s2_acc_q, s2_cxl_q;

  logic             rsp_valid_q;
  logic [1:0]       rsp_op_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic             rsp_accept_q;
  logic [AMT_W-1:0] rsp_headroom_q;

  // S2 results
  logic [AMT_W-1:0] s2_max_new, s2_acc_new, s2_cxl_new;
  logic             s2_accept;
  logic [AMT_W-1:0] s2_headroom;
  logic [AMT_W+1:0] order_net;
  logic [AMT_W:0]   order_net_pos;
  logic [AMT_W:0]   post_net_full;
  logic [AMT_W-1:0] post_net;

  // Write port and snapshot selection
  logic             wr_en;
  logic [AMT_W-1:0] cap_max, cap_acc, cap_cxl;
  logic [AMT_W-1:0] fwd_max, fwd_acc, fwd_cxl;

  assign adv       = !rsp_valid_q || rsp_ready;
  assign req_ready = adv;
  assign wr_en     = adv && s2_valid_q;

  // ---------------------------------------------------------------------------
  // S2 compute: new entry, accept decision and post-op headroom
  // ---------------------------------------------------------------------------
  always_comb begin
    s2_max_new = s2_max_q;
    s2_acc_new = s2_acc_q;
    s2_cxl_new = s2_cxl_q;
    s2_accept  = 1'b1;

    // acc + amt cannot reach bit AMT_W+1, so that bit set means the result is negative.
    order_net     = {2'b00, s2_acc_q} + {2'b00, s2_amt_q} - {2'b00, s2_cxl_q};
    order_net_pos = order_net[AMT_W+1] ? '0 : order_net[AMT_W:0];

    unique case (s2_op_q)
      OpOrder: begin
        s2_accept = (order_net_pos <= {1'b0, s2_max_q});
        if (s2_accept) begin
          s2_acc_new = sat_add(s2_acc_q, s2_amt_q);
        end
      end
      OpCancel: s2_cxl_new = sat_add(s2_cxl_q, s2_amt_q);
      OpSetMax: s2_max_new = s2_amt_q;
      OpClear: begin
        s2_acc_new = '0;
        s2_cxl_new = '0;
      end
    endcase

    post_net_full = {1'b0, s2_acc_new} - {1'b0, s2_cxl_new};
    post_net      = post_net_full[AMT_W] ? '0 : post_net_full[AMT_W-1:0];
    s2_headroom   = (s2_max_new >= post_net) ? (s2_max_new - post_net) : '0;
  end

  // ---------------------------------------------------------------------------
  // Snapshot selection. An entry written by S2 on this edge supersedes the table
  // copy and the S1 snapshot, so same-id back-to-back requests see sequential state.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (wr_en && (s2_id_q == req_id)) begin
      cap_max = s2_max_new;
      cap_acc = s2_acc_new;
      cap_cxl = s2_cxl_new;
    end else begin
      cap_max = max_q[req_id];
      cap_acc = acc_q[req_id];
      cap_cxl = cxl_q[req_id];
    end
  end

  always_comb begin
    if (wr_en && (s2_id_q == s1_id_q)) begin
      fwd_max = s2_max_new;
      fwd_acc = s2_acc_new;
      fwd_cxl = s2_cxl_new;
    end else begin
      fwd_max = s1_max_q;
      fwd_acc = s1_acc_q;
      fwd_cxl = s1_cxl_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Table write-back
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        max_q[i] <= '0;
        acc_q[i] <= '0;
        cxl_q[i] <= '0;
      end
    end else if (wr_en) begin
      max_q[s2_id_q] <= s2_max_new;
      acc_q[s2_id_q] <= s2_acc_new;
      cxl_q[s2_id_q] <= s2_cxl_new;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OpOrder;
      s1_id_q    <= '0;
      s1_amt_q   <= '0;
      s1_max_q   <= '0;
      s1_acc_q   <= '0;
      s1_cxl_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= req_valid;
      s1_op_q    <= op_e'(req_op);
      s1_id_q    <= req_id;
      s1_amt_q   <= req_amt;
      s1_max_q   <= cap_max;
      s1_acc_q   <= cap_acc;
      s1_cxl_q   <= cap_cxl;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: request plus refreshed snapshot
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_op_q    <= OpOrder;
      s2_id_q    <= '0;
      s2_amt_q   <= '0;
      s2_max_q   <= '0;
      s2_acc_q   <= '0;
      s2_cxl_q   <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_op_q    <= s1_op_q;
      s2_id_q    <= s1_id_q;
      s2_amt_q   <= s1_amt_q;
      s2_max_q   <= fwd_max;
      s2_acc_q   <= fwd_acc;
      s2_cxl_q   <= fwd_cxl;
    end
  end

  // ---------------------------------------------------------------------------
  // Response register; payload only reloads when S2 carries a request.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q    <= 1'b0;
      rsp_op_q       <= 2'b00;
      rsp_id_q       <= '0;
      rsp_accept_q   <= 1'b0;
      rsp_headroom_q <= '0;
    end else if (adv) begin
      rsp_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        rsp_op_q       <= s2_op_q;
        rsp_id_q       <= s2_id_q;
        rsp_accept_q   <= s2_accept;
        rsp_headroom_q <= s2_headroom;
      end
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_op       = rsp_op_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_accept   = rsp_accept_q;
  assign rsp_headroom = rsp_headroom_q;

`ifdef RISK_REJCNT_EN
  // ---------------------------------------------------------------------------
  // Rejected-order counter, saturating, cleared only by reset.
  // ---------------------------------------------------------------------------
  logic [15:0] rej_count_q;
  logic        rej_event;

  assign rej_event = wr_en && (s2_op_q == OpOrder) && !s2_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rej_count_q <= '0;
    end else if (rej_event && (rej_count_q != 16'hFFFF)) begin
      rej_count_q <= rej_count_q + 16'd1;
    end
  end

  assign rej_count = rej_count_q;
`endif

endmodule
